// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl_if
//  Description : Bundle between the FIFO controller and its environment
//                (producer/consumer requests, datapath status inputs,
//                datapath strobes and status outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_ctrl_if #(
    parameter int PTR_WIDTH = 10
);
    // Requests and datapath status flowing into the controller
    logic                 wr_req;
    logic                 rd_req;
    logic                 clr_err;
    logic                 count_eq_0;
    logic                 count_gt_512;

    // Datapath strobes and status flowing out of the controller
    logic                 write_mem;
    logic                 inc_wr;
    logic                 inc_rd;
    logic                 inc_count;
    logic                 dec_count;
    logic                 rd_valid;
    logic                 primed;
    logic                 full;
    logic [PTR_WIDTH:0]   level;
    logic                 ovf_err;
    logic                 udf_err;
    logic                 sync_err;

    // Environment side: producer, consumer and datapath
    modport master (
        output wr_req, rd_req, clr_err, count_eq_0, count_gt_512,
        input  write_mem, inc_wr, inc_rd, inc_count, dec_count,
        input  rd_valid, primed, full, level, ovf_err, udf_err, sync_err
    );

    // Controller side
    modport slave (
        input  wr_req, rd_req, clr_err, count_eq_0, count_gt_512,
        output write_mem, inc_wr, inc_rd, inc_count, dec_count,
        output rd_valid, primed, full, level, ovf_err, udf_err, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Control FSM sequencing the 1024x16 sample buffer datapath
//                between the I2S producer and the audio consumer. Blocks
//                reads until more than half full, tracks occupancy, and
//                reports overflow / underrun / counter-desync errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int DEPTH     = 1024,
    parameter int PTR_WIDTH = 10
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fifo_ctrl_if.slave  bus
);

    localparam logic [0:0]         S_PRIME   = 1'b0;
    localparam logic [0:0]         S_RUN     = 1'b1;
    localparam logic [PTR_WIDTH:0] C_DEPTH   = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] C_OCC_ONE = (PTR_WIDTH+1)'(1);

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [PTR_WIDTH:0] r_occ;
    logic               r_rd_valid;
    logic               r_ovf_err;
    logic               r_udf_err;
    logic               r_sync_err;

    logic               w_full;
    logic               w_run;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_ovf_set;
    logic               w_udf_set;
    logic               w_sync_set;

    logic               w_write_mem;
    logic               w_inc_wr;
    logic               w_inc_rd;
    logic               w_inc_count;
    logic               w_dec_count;

    // Acceptance decisions: full is the pre-pop value, so a push at full is
    // dropped even when a pop happens in the same cycle.
    assign w_full     = (r_occ == C_DEPTH);
    assign w_run      = (r_state == S_RUN);
    assign w_push_ok  = bus.wr_req & ~w_full;
    assign w_pop_ok   = bus.rd_req & w_run & ~bus.count_eq_0;

    // Error set conditions
    assign w_ovf_set  = bus.wr_req & w_full;
    assign w_udf_set  = bus.rd_req & w_run & bus.count_eq_0;
    assign w_sync_set = bus.count_eq_0 ^ (r_occ == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: prime until over half full, fall back on a pop at empty
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_PRIME: begin
                if (bus.count_gt_512) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.rd_req && bus.count_eq_0) begin
                    w_next_state = S_PRIME;
                end
            end
            default: w_next_state = S_PRIME;
        endcase
    end

    // Datapath strobes for the accepted push/pop of this cycle
    always_comb begin
        w_write_mem = w_push_ok;
        w_inc_wr    = w_push_ok;
        w_inc_rd    = w_pop_ok;
        w_inc_count = w_push_ok & ~w_pop_ok;
        w_dec_count = w_pop_ok & ~w_push_ok;
    end

    // Occupancy tracking, read-valid pipeline and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= '0;
            r_rd_valid <= 1'b0;
            r_ovf_err  <= 1'b0;
            r_udf_err  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + C_OCC_ONE;
                2'b01:   r_occ <= r_occ - C_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
            r_rd_valid <= w_pop_ok;
            // Set wins over a simultaneous clear
            r_ovf_err  <= w_ovf_set  | (r_ovf_err  & ~bus.clr_err);
            r_udf_err  <= w_udf_set  | (r_udf_err  & ~bus.clr_err);
            r_sync_err <= w_sync_set | (r_sync_err & ~bus.clr_err);
        end
    end

    assign bus.write_mem = w_write_mem;
    assign bus.inc_wr    = w_inc_wr;
    assign bus.inc_rd    = w_inc_rd;
    assign bus.inc_count = w_inc_count;
    assign bus.dec_count = w_dec_count;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.primed    = w_run;
    assign bus.full      = w_full;
    assign bus.level     = r_occ;
    assign bus.ovf_err   = r_ovf_err;
    assign bus.udf_err   = r_udf_err;
    assign bus.sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl
//  Description : Self-checking bench for fifo_ctrl with a behavioural
//                datapath and a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    localparam int DEPTH     = 1024;
    localparam int PTR_WIDTH = 10;

    logic clk;
    logic rst;

    fifo_ctrl_if #(.PTR_WIDTH(PTR_WIDTH)) u_bus ();

    fifo_ctrl #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural datapath ----------------
    logic [15:0]          dp_mem [DEPTH];
    logic [PTR_WIDTH-1:0] dp_wp;
    logic [PTR_WIDTH-1:0] dp_rp;
    logic [PTR_WIDTH:0]   dp_cnt;
    logic [15:0]          dp_out;
    logic [15:0]          din;
    logic                 corrupt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_wp  <= '0;
            dp_rp  <= '0;
            dp_cnt <= '0;
            dp_out <= '0;
        end else begin
            if (u_bus.write_mem) dp_mem[dp_wp] <= din;
            if (u_bus.inc_wr)    dp_wp <= dp_wp + 1'b1;
            if (u_bus.inc_rd) begin
                dp_out <= dp_mem[dp_rp];
                dp_rp  <= dp_rp + 1'b1;
            end
            if (u_bus.inc_count)      dp_cnt <= dp_cnt + 1'b1;
            else if (u_bus.dec_count) dp_cnt <= dp_cnt - 1'b1;
        end
    end

    assign u_bus.count_eq_0   = (dp_cnt == '0) ^ corrupt;
    assign u_bus.count_gt_512 = (dp_cnt > 512);

    // ---------------- reference model state ----------------
    int          m_occ;
    bit          m_run;
    bit          m_rdv;
    logic [15:0] m_rdata;
    bit          m_ovf, m_udf, m_sync;
    logic [15:0] m_q[$];

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ  = 0;
        m_run  = 0;
        m_rdv  = 0;
        m_ovf  = 0;
        m_udf  = 0;
        m_sync = 0;
        m_q.delete();
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    task automatic step(input bit wr, input bit rd, input bit clr, input bit bad);
        bit e_full, ceq0, cgt, push, pop;
        u_bus.wr_req  = wr;
        u_bus.rd_req  = rd;
        u_bus.clr_err = clr;
        corrupt       = bad;
        #1;
        e_full = (m_occ == DEPTH);
        ceq0   = u_bus.count_eq_0;
        cgt    = u_bus.count_gt_512;
        push   = wr && !e_full;
        pop    = rd && m_run && !ceq0;
        chk("write_mem", u_bus.write_mem, push);
        chk("inc_wr",    u_bus.inc_wr,    push);
        chk("inc_rd",    u_bus.inc_rd,    pop);
        chk("inc_count", u_bus.inc_count, push && !pop);
        chk("dec_count", u_bus.dec_count, pop && !push);
        chk("primed",    u_bus.primed,    m_run);
        chk("full",      u_bus.full,      e_full);
        chk("level",     u_bus.level,     m_occ);
        chk("rd_valid",  u_bus.rd_valid,  m_rdv);
        chk("ovf_err",   u_bus.ovf_err,   m_ovf);
        chk("udf_err",   u_bus.udf_err,   m_udf);
        chk("sync_err",  u_bus.sync_err,  m_sync);
        if (m_rdv) chk("rd_data", dp_out, m_rdata);
        @(posedge clk);
        m_sync = (ceq0 != (m_occ == 0)) || (m_sync && !clr);
        m_ovf  = (wr && e_full)         || (m_ovf && !clr);
        m_udf  = (rd && m_run && ceq0)  || (m_udf && !clr);
        if (push) m_q.push_back(din);
        if (pop && m_q.size() > 0) m_rdata = m_q.pop_front();
        m_rdv = pop;
        if (push && !pop) m_occ++;
        if (pop && !push) m_occ--;
        if (!m_run && cgt)             m_run = 1;
        else if (m_run && rd && ceq0)  m_run = 0;
        @(negedge clk);
        if (push) din = din + 16'd1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        din   = 16'h0001;
        corrupt = 1'b0;
        u_bus.wr_req  = 1'b0;
        u_bus.rd_req  = 1'b0;
        u_bus.clr_err = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_level",  u_bus.level,    0);
        chk("rst_primed", u_bus.primed,   0);
        chk("rst_rdv",    u_bus.rd_valid, 0);
        chk("rst_flags",  {u_bus.ovf_err, u_bus.udf_err, u_bus.sync_err}, 0);
        chk("rst_strobe", u_bus.write_mem, 0);
        @(negedge clk);
        rst = 1'b0;

        // Prime with 513 pushes; read requests in PRIME must be ignored
        for (int i = 0; i < 513; i++) step(1'b1, (i % 50) == 7, 1'b0, 1'b0);
        chk("prime_level", u_bus.level, 513);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("primed_up", u_bus.primed, 1);

        // Pop three; data 1,2,3 checked by the model
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pop3_level", u_bus.level, 510);

        // Fill to full, overflow, push+pop at full, clear
        for (int i = 0; i < 1100 && m_occ < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fill_full", u_bus.full, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_set",   u_bus.ovf_err, 1);
        chk("ovf_level", u_bus.level, 1024);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_pp_level", u_bus.level, 1023);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", u_bus.ovf_err, 0);

        // Streaming push+pop
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("stream_level", u_bus.level, 1023);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 3, 1'b0);

        // Reach RUN, drain, underrun back to PRIME
        for (int i = 0; i < 1200 && !m_run; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1100 && m_occ > 0; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain_level", u_bus.level, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("udf_set",     u_bus.udf_err, 1);
        chk("udf_primed",  u_bus.primed, 0);
        for (int i = 0; i < 300; i++) step(1'b1, i[0], 1'b0, 1'b0);
        chk("reprime_level", u_bus.level, 300);

        // Build to 701 then pop once, reset with the read in flight
        for (int i = 0; i < 1000 && m_occ < 701; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_level", u_bus.level, 700);
        chk("pre_rst_rdv",   u_bus.rd_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_level",  u_bus.level,    0);
        chk("arst_primed", u_bus.primed,   0);
        chk("arst_rdv",    u_bus.rd_valid, 0);
        chk("arst_flags",  {u_bus.ovf_err, u_bus.udf_err, u_bus.sync_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40, 1'b0, 1'b0);

        // Desync detection, set-wins-over-clear, then clear
        for (int i = 0; i < 1100 && m_occ > 0; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sync_set", u_bus.sync_err, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("sync_set_wins", u_bus.sync_err, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("sync_clr", u_bus.sync_err, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control FSM that sequences fifo_datapath (1024x16 sample buffer) between the I2S receiver (producer) and the audio consumer.
- Converts producer push pulses and consumer pop pulses into the datapath strobes write_mem, inc_wr, inc_rd, inc_count and dec_count.
- Holds reads off until the buffer is primed past half full, tracks occupancy to detect full, and reports overflow/underrun.
- Generates rd_valid aligned to the datapath's registered read output.

Parameters:
- DEPTH, 1024, datapath entries; must match fifo_datapath DEPTH.
- PTR_WIDTH, 10, log2(DEPTH); occupancy counter is PTR_WIDTH+1 bits.

Ports:
- clk  in  1  system clock; same clock as fifo_datapath.
- rst  in  1  asynchronous, active-high reset; shared with fifo_datapath.
- wr_req  in  1  producer push request, one sample per cycle when high.
- rd_req  in  1  consumer pop request, one sample per cycle when high.
- clr_err  in  1  synchronous clear of the sticky error flags.
- count_eq_0  in  1  from datapath: stored count == 0.
- count_gt_512  in  1  from datapath: stored count > 512.
- write_mem  out  1  to datapath: write Dato_In at wr_ptr.
- inc_wr  out  1  to datapath: advance wr_ptr.
- inc_rd  out  1  to datapath: advance rd_ptr.
- inc_count  out  1  to datapath: count +1.
- dec_count  out  1  to datapath: count -1.
- rd_valid  out  1  datapath Out holds the popped sample this cycle.
- primed  out  1  high in state RUN.
- full  out  1  occ == DEPTH.
- level  out  PTR_WIDTH+1  internal occupancy occ.
- ovf_err  out  1  sticky: push dropped because the buffer was full.
- udf_err  out  1  sticky: pop requested in RUN while empty.
- sync_err  out  1  sticky: count_eq_0 != (occ == 0).

Behaviour:
- Reset values (rst high): state PRIME, occ=0, rd_valid=0, all three error flags 0. Datapath strobes are combinational and 0 while no push/pop is accepted.
- States: PRIME (reads blocked) and RUN (reads enabled).
- push_ok = wr_req & ~full. This is independent of state; pushes are accepted in both PRIME and RUN.
- pop_ok = rd_req & (state==RUN) & ~count_eq_0.
- Strobe generation is combinational in the same cycle:
  - write_mem = inc_wr = push_ok.
  - inc_rd = pop_ok.
  - inc_count = push_ok & ~pop_ok.
  - dec_count = pop_ok & ~push_ok.
  - inc_count and dec_count are never both 1.
- Simultaneous push_ok and pop_ok: both pointers advance, count and occ are unchanged.
- occ updates on the clock edge: +1 on push only, -1 on pop only. It never exceeds DEPTH and never goes below 0.
- Full with push and pop in the same cycle: in RUN the pop makes room, so push_ok uses full, not the post-pop value, and the push is dropped.
  - The push is dropped, ovf_err is set, and the pop proceeds.
  - Result: occ becomes DEPTH-1.
- Push while full with no pop: dropped, no strobes, ovf_err <= 1.
- rd_valid is a registered copy of pop_ok. It goes high exactly 1 cycle after the pop cycle, when Out = MEM[old rd_ptr].
- Transitions:
  - PRIME -> RUN when count_gt_512 = 1 (513 or more stored).
  - RUN -> PRIME when rd_req = 1 and count_eq_0 = 1. In that cycle udf_err <= 1 and no strobe is issued.
  - RUN stays in RUN while the buffer is empty and no pop is requested.
- rd_req in PRIME is ignored: no strobe, no rd_valid, no error.
- Sticky flags:
  - Set by their conditions, cleared by clr_err.
  - If a flag's set condition and clr_err occur in the same cycle, set wins.
- sync_err is evaluated every cycle outside reset. It flags a desync between the datapath counter and occ.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. Any rd_valid in flight is cancelled.

Test Plan:
- Reset then 513 pushes (wr_req held 513 cycles): primed rises the cycle after the 513th push, level=513, no rd_valid before that. rd_req pulses during PRIME produce no inc_rd.
- Push values 0x0001..0x0201, then pop 3: inc_rd is high in the pop cycles, and rd_valid with Out = 0x0001, 0x0002, 0x0003 appears one cycle later each. level=510.
- Fill to 1024 (full=1), then 1 push: write_mem=0, ovf_err=1, level=1024. Then push+pop in the same cycle: pop accepted, push dropped, level=1023. Then clr_err -> ovf_err=0.
- In RUN, simultaneous push and pop for 100 cycles: inc_wr=inc_rd=1, inc_count=dec_count=0, level constant, data order preserved.
- In RUN, drain to 0, then rd_req: no inc_rd, udf_err=1, state returns to PRIME. The next pops are ignored until 513 entries are stored again.
- Assert rst while level=700 and a pop is in flight: level=0, primed=0, rd_valid=0 the same cycle, all flags 0, and sync_err stays 0 afterwards.
